// File: rtl/enable_sequence_scheduler_if.sv
// Control/configuration bus of the enable sequence scheduler.
// The master drives the start/abort handshake and config writes.
// The slave (the scheduler) returns the enables and the status pulses.
interface enable_sequence_scheduler_if #(
  parameter int NUM_EN = 10,
  parameter int CNT_W  = 4,
  parameter int REP_W  = 8
) ();
  logic              start_i;
  logic [REP_W-1:0]  rep_i;
  logic              abort_i;
  logic              cfg_we_i;
  logic [3:0]        cfg_sel_i;
  logic [CNT_W-1:0]  cfg_start_i;
  logic [CNT_W-1:0]  cfg_len_i;
  logic [NUM_EN-1:0] enable_o;
  logic              busy_o;
  logic              done_o;
  logic              abort_ack_o;
  logic              cfg_err_o;

  modport master (
    output start_i, rep_i, abort_i, cfg_we_i, cfg_sel_i, cfg_start_i, cfg_len_i,
    input  enable_o, busy_o, done_o, abort_ack_o, cfg_err_o
  );

  modport slave (
    input  start_i, rep_i, abort_i, cfg_we_i, cfg_sel_i, cfg_start_i, cfg_len_i,
    output enable_o, busy_o, done_o, abort_ack_o, cfg_err_o
  );
endinterface

// File: rtl/enable_sequence_scheduler.sv
// Register-programmable enable sequencer.
// Each channel is high for a programmed window inside a frame.
// Frames repeat back-to-back for the requested count.
// A start/busy/done handshake with abort controls each sequence.
// Reset defaults reproduce the legacy fixed 10-enable schedule.
module enable_sequence_scheduler #(
  parameter int NUM_EN = 10,
  parameter int CNT_W  = 4,
  parameter int REP_W  = 8
) (
  input logic clk_i,
  input logic reset_i,
  enable_sequence_scheduler_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] SEL_FLEN = 4'hF;
  localparam logic [3:0] NUM_EN_L = 4'(NUM_EN);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [REP_W-1:0]  frame_q, frame_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [NUM_EN-1:0] en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  start_q [NUM_EN];
  logic [CNT_W-1:0]  len_q   [NUM_EN];
  logic [CNT_W-1:0]  flen_q;

  logic start_acc, last_cyc, last_frame, cfg_ok, cfg_wr;

  // A start is taken only from IDLE and only when abort is low.
  // A write in that same cycle is rejected as if the FSM were already busy.
  assign start_acc  = (state_q == IDLE) && bus.start_i && !bus.abort_i;
  assign last_cyc   = (cyc_q == flen_q - CNT_W'(1));
  assign last_frame = (frame_q == rep_q - REP_W'(1));
  assign cfg_ok     = (bus.cfg_sel_i < NUM_EN_L) ||
                      ((bus.cfg_sel_i == SEL_FLEN) && (bus.cfg_start_i != '0));
  assign cfg_wr     = bus.cfg_we_i && (state_q == IDLE) && !start_acc && cfg_ok;

  // Channel window decode for frame cycle c.
  // The end bound is one bit wider, so start+len never wraps.
  // Truncation at the frame end is implicit: cyc never reaches frame_len.
  function automatic logic [NUM_EN-1:0] decode(input logic [CNT_W-1:0] c);
    logic [CNT_W:0] end_c;
    decode = '0;
    for (int k = 0; k < NUM_EN; k++) begin
      end_c     = {1'b0, start_q[k]} + {1'b0, len_q[k]};
      decode[k] = (len_q[k] != '0) && (c >= start_q[k]) && ({1'b0, c} < end_c);
    end
  endfunction

  // State and datapath registers; async reset restores the default schedule
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      frame_q <= '0;
      rep_q   <= REP_W'(1);
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      flen_q  <= CNT_W'(10);
      for (int k = 0; k < NUM_EN; k++) begin
        start_q[k] <= CNT_W'(k);
        len_q[k]   <= (k == 2) ? CNT_W'(2) : CNT_W'(1);
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      frame_q <= frame_d;
      rep_q   <= rep_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (cfg_wr && (bus.cfg_sel_i == SEL_FLEN)) flen_q <= bus.cfg_start_i;
      for (int k = 0; k < NUM_EN; k++) begin
        if (cfg_wr && (bus.cfg_sel_i == 4'(k))) begin
          start_q[k] <= bus.cfg_start_i;
          len_q[k]   <= bus.cfg_len_i;
        end
      end
    end
  end

  // Next-state: abort has priority over completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = RUN;
      RUN:     if (bus.abort_i || (last_cyc && last_frame)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and counters: enables are registered one cycle ahead of the frame cycle
  always_comb begin
    cyc_d   = cyc_q;
    frame_d = frame_q;
    rep_d   = rep_q;
    en_d    = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = bus.cfg_we_i && !cfg_wr;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          cyc_d   = '0;
          frame_d = '0;
          rep_d   = (bus.rep_i == '0) ? REP_W'(1) : bus.rep_i;
          en_d    = decode('0);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          ack_d = 1'b1;
          cyc_d = '0;
        end else if (last_cyc && last_frame) begin
          done_d = 1'b1;
          cyc_d  = '0;
        end else if (last_cyc) begin
          busy_d  = 1'b1;
          cyc_d   = '0;
          frame_d = frame_q + REP_W'(1);
          en_d    = decode('0);
        end else begin
          busy_d = 1'b1;
          cyc_d  = cyc_q + CNT_W'(1);
          en_d   = decode(cyc_q + CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  assign bus.enable_o    = en_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.abort_ack_o = ack_q;
  assign bus.cfg_err_o   = err_q;

endmodule

// File: tb/tb_enable_sequence_scheduler.sv
// Directed bench for enable_sequence_scheduler.
module tb_enable_sequence_scheduler;
  localparam int NUM_EN = 10;
  localparam int CNT_W  = 4;
  localparam int REP_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   d0;
  logic [NUM_EN-1:0] exp_tbl [16];

  enable_sequence_scheduler_if #(.NUM_EN(NUM_EN), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  enable_sequence_scheduler #(.NUM_EN(NUM_EN), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] sel, input logic [3:0] st, input logic [3:0] ln,
                           input logic exp_err);
    bus.cfg_we_i = 1'b1; bus.cfg_sel_i = sel; bus.cfg_start_i = st; bus.cfg_len_i = ln;
    tick();
    bus.cfg_we_i = 1'b0;
    chk($sformatf("cfg_err_sel%0d", sel), 32'(bus.cfg_err_o), 32'(exp_err));
  endtask

  task automatic run_seq(input logic [7:0] rep, input int n, input int fl, input string tag);
    bus.rep_i = rep; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s_en%0d", tag, c), 32'(bus.enable_o), 32'(exp_tbl[c % fl]));
      chk($sformatf("%s_busy%0d", tag, c), 32'(bus.busy_o), 32'd1);
      tick();
    end
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_en_end"}, 32'(bus.enable_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.rep_i = '0; bus.abort_i = 1'b0;
    bus.cfg_we_i = 1'b0; bus.cfg_sel_i = '0; bus.cfg_start_i = '0; bus.cfg_len_i = '0;
    #12;
    chk("rst_en", 32'(bus.enable_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_ack", 32'(bus.abort_ack_o), 32'd0);
    chk("rst_err", 32'(bus.cfg_err_o), 32'd0);
    rst = 1'b0;
    tick();

    // Default schedule
    exp_tbl = '{10'h001, 10'h002, 10'h004, 10'h00C, 10'h010, 10'h020, 10'h040, 10'h080,
                10'h100, 10'h200, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    run_seq(8'd1, 10, 10, "dflt");

    // Reprogram ch0 to 3/4 with frame length 6, two frames
    cfg_write(4'd0, 4'd3, 4'd4, 1'b0);
    cfg_write(4'd15, 4'd6, 4'd0, 1'b0);
    exp_tbl = '{10'h000, 10'h002, 10'h004, 10'h00D, 10'h011, 10'h021, 10'h000, 10'h000,
                10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    run_seq(8'd2, 12, 6, "rep2");

    // Boundaries: disabled channel, start at 15, 5-bit end bound, max frame, rep 0
    cfg_write(4'd5, 4'd5, 4'd0, 1'b0);
    cfg_write(4'd9, 4'd15, 4'd15, 1'b0);
    cfg_write(4'd8, 4'd14, 4'd3, 1'b0);
    cfg_write(4'd15, 4'd15, 4'd0, 1'b0);
    exp_tbl = '{10'h000, 10'h002, 10'h004, 10'h00D, 10'h011, 10'h001, 10'h041, 10'h080,
                10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h100, 10'h000};
    run_seq(8'd0, 15, 15, "bnd");

    // Abort in frame 2 cycle 4 (frame length 6)
    cfg_write(4'd15, 4'd6, 4'd0, 1'b0);
    d0 = done_cnt;
    bus.rep_i = 8'd3; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abt_pre_en", 32'(bus.enable_o), 32'h011);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abt_en", 32'(bus.enable_o), 32'd0);
    chk("abt_busy", 32'(bus.busy_o), 32'd0);
    chk("abt_ack", 32'(bus.abort_ack_o), 32'd1);
    chk("abt_done", 32'(bus.done_o), 32'd0);
    tick();
    chk("abt_ack_pulse", 32'(bus.abort_ack_o), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("abt_no_done", 32'(done_cnt), 32'(d0));
    chk("abt_idle_busy", 32'(bus.busy_o), 32'd0);

    // Abort together with start in IDLE: abort wins
    bus.abort_i = 1'b1; bus.start_i = 1'b1; bus.rep_i = 8'd1;
    tick();
    bus.abort_i = 1'b0; bus.start_i = 1'b0;
    chk("abtst_busy", 32'(bus.busy_o), 32'd0);
    chk("abtst_ack", 32'(bus.abort_ack_o), 32'd0);
    chk("abtst_en", 32'(bus.enable_o), 32'd0);

    // Rejected writes: during RUN, bad selector, zero frame length, with start
    exp_tbl = '{10'h000, 10'h002, 10'h004, 10'h00D, 10'h011, 10'h001, 10'h000, 10'h000,
                10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    bus.rep_i = 8'd1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    cfg_write(4'd0, 4'd0, 4'd15, 1'b1);
    chk("rej_run_en", 32'(bus.enable_o), 32'h004);
    for (int i = 0; i < 4; i++) tick();
    chk("rej_run_done", 32'(bus.done_o), 32'd1);
    cfg_write(4'd12, 4'd1, 4'd1, 1'b1);
    cfg_write(4'd15, 4'd0, 4'd0, 1'b1);
    bus.start_i = 1'b1; bus.rep_i = 8'd1;
    bus.cfg_we_i = 1'b1; bus.cfg_sel_i = 4'd0; bus.cfg_start_i = 4'd0; bus.cfg_len_i = 4'd15;
    tick();
    bus.start_i = 1'b0; bus.cfg_we_i = 1'b0;
    chk("rej_st_err", 32'(bus.cfg_err_o), 32'd1);
    chk("rej_st_busy", 32'(bus.busy_o), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("rej_st_done", 32'(bus.done_o), 32'd1);
    run_seq(8'd1, 6, 6, "rerun");

    // Asynchronous reset mid-frame restores defaults
    bus.rep_i = 8'd1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    chk("ar_pre_en", 32'(bus.enable_o), 32'h004);
    #2 rst = 1'b1;
    #1;
    chk("ar_en", 32'(bus.enable_o), 32'd0);
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    chk("ar_done", 32'(bus.done_o), 32'd0);
    #2 rst = 1'b0;
    tick();
    exp_tbl = '{10'h001, 10'h002, 10'h004, 10'h00C, 10'h010, 10'h020, 10'h040, 10'h080,
                10'h100, 10'h200, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    run_seq(8'd1, 10, 10, "post_rst");

    // Start in the done cycle
    bus.start_i = 1'b1; bus.rep_i = 8'd1;
    tick();
    bus.start_i = 1'b0;
    chk("bb_en", 32'(bus.enable_o), 32'h001);
    chk("bb_busy", 32'(bus.busy_o), 32'd1);
    chk("bb_done", 32'(bus.done_o), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("bb_done_end", 32'(bus.done_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/enable_sequence_scheduler.md
Name: enable_sequence_scheduler

Overview:
- Programmable sequencer that generates the per-cycle enable pulses consumed by the enable-controller datapath. It replaces a fixed schedule with a register-configured one.
- Each channel has a start cycle and a duration within a frame of programmable length.
- Frames run back-to-back for a requested repeat count, under a start/busy/done handshake with abort.
- Reset defaults reproduce the existing 10-enable schedule.

Parameters:
- NUM_EN, 10, number of enable channels (1..15).
- CNT_W, 4, width of the frame-cycle counter and of the start/length fields. Frame length range is 1..2^CNT_W-1.
- REP_W, 8, width of the repeat count.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- rep_i  in  REP_W  number of frames, sampled with start_i; 0 is treated as 1.
- abort_i  in  1  terminates a running sequence.
- cfg_we_i  in  1  configuration write strobe.
- cfg_sel_i  in  4  channel index 0..NUM_EN-1; 15 selects the frame-length register.
- cfg_start_i  in  CNT_W  channel start cycle; frame length when cfg_sel_i=15.
- cfg_len_i  in  CNT_W  channel duration in cycles; 0 disables the channel. Ignored when cfg_sel_i=15.
- enable_o  out  NUM_EN  registered enables; bit k drives channel k+1 of the datapath.
- busy_o  out  1  high while a sequence is in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- abort_ack_o  out  1  one-cycle pulse when an abort is taken.
- cfg_err_o  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset values:
  - enable_o=0, busy_o=0, done_o=0, abort_ack_o=0, cfg_err_o=0, state IDLE, cyc=0, frame counter=0.
  - Channel k: start=k, len=1, except channel 2, which has len=2.
  - frame_len=10.
- FSM states: IDLE and RUN.
- IDLE -> RUN:
  - Taken at the edge where start_i=1 and abort_i=0.
  - At that edge: latch max(rep_i,1), set cyc=0, busy_o=1, and load enable_o with the decode of cycle 0.
  - Result: frame cycle c is visible on enable_o in the (c+1)-th clock after the start edge (1-cycle latency).
- Channel decode: enable_o[k]=1 for frame cycle c iff len_k!=0 and start_k <= c < start_k+len_k.
  - The sum start_k+len_k is computed in CNT_W+1 bits, so it never wraps.
  - Any portion of the interval at or beyond frame_len is truncated.
  - Overlapping channels are independent; there is no mutual exclusion.
- Frame sequencing:
  - cyc runs 0..frame_len-1.
  - After the last cycle, cyc returns to 0 for the next frame with no gap.
  - The frame counter increments at each wrap.
- Completion:
  - At the edge that would leave the last cycle of the last frame: go to IDLE, enable_o=0, busy_o=0, done_o=1 for exactly one cycle.
  - A new start_i in that same IDLE cycle is accepted. done_o and the new busy_o may be high together.
- start_i while in RUN is ignored, with no error flag.
- abort_i in RUN:
  - At the next edge: go to IDLE, enable_o=0, busy_o=0, abort_ack_o=1 for one cycle.
  - done_o is not asserted.
  - abort_i has priority over completion in the same cycle.
- abort_i with start_i in IDLE: abort wins. Stay IDLE, no ack, no start.
- Configuration writes:
  - Accepted only in IDLE and take effect on the next start.
  - Rejected, with a cfg_err_o pulse and no state change, if any of these hold:
    - busy_o=1;
    - cfg_sel_i is in NUM_EN..14;
    - cfg_sel_i=15 with cfg_start_i=0.
  - A write in the same cycle as an accepted start is rejected, because the FSM is treated as busy.
- Asynchronous reset mid-sequence forces all reset values immediately. The configuration returns to defaults.

Test Plan:
- Default schedule:
  - Stimulus: reset, then start_i with rep_i=1.
  - Expect: clock 1 has enable_o=0x001, clock 2 0x002, clock 3 0x004, clock 4 0x00C, then 0x010 through 0x200 on clocks 5-10.
  - Expect: done_o on clock 11, busy_o high for clocks 1-10.
- Reprogram and repeat:
  - Stimulus: write ch0 start=3 len=4; write frame_len=6; start with rep_i=2.
  - Expect: bit0 high on frame cycles 3-5 only (truncated at frame end) in both frames, 12 busy cycles, then done_o.
- Boundary values:
  - Stimulus: write ch5 len=0; write ch9 start=15 len=15; start with rep_i=0.
  - Expect: bits 5 and 9 never assert, exactly one frame runs.
- Abort:
  - Stimulus: start with rep_i=3, assert abort_i in frame 2 cycle 4.
  - Expect: next clock enable_o=0, busy_o=0, abort_ack_o=1, and done_o never asserts.
- Rejected writes:
  - Stimulus: cfg_we_i during RUN; cfg_sel_i=12; frame_len=0.
  - Expect: each gives a cfg_err_o pulse, and a rerun shows the unchanged schedule.
- Reset and start corner cases:
  - Stimulus: assert reset_i asynchronously mid-frame.
  - Expect: all outputs 0 immediately and defaults restored.
  - Stimulus: start_i in the done_o cycle.
  - Expect: a new sequence begins, enable_o=0x001 on the next clock.
